// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back mux, 32x32 register file and commit counter
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              startin,
  input  logic [DATA_W-1:0] read_data_input,
  input  logic [DATA_W-1:0] alu_result_input,
  input  logic [ADDR_W-1:0] write_register_input,
  input  logic [1:0]        WB_input,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_reg_write,
  output logic [31:0]       commit_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [31:0]       commit_count_q;
  logic [31:0]       commit_count_d;

  assign wb_write_data  = WB_input[0] ? read_data_input : alu_result_input;
  assign wb_reg_write   = WB_input[1] && (write_register_input != '0);
  assign commit_count_d = commit_count_q + 32'd1;
  assign commit_count   = commit_count_q;

  // Reset wins over a write presented on the same edge.
  always_ff @(posedge clock) begin
    if (startin) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      commit_count_q <= '0;
    end else if (wb_reg_write) begin
      regs_q[write_register_input] <= wb_write_data;
      commit_count_q <= commit_count_d;
    end
  end

  // wb_reg_write already excludes index 0, so the bypass can never expose $0.
  always_comb begin
    read_data1 = (read_reg1 == '0) ? '0 : regs_q[read_reg1];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_reg_write && (read_reg1 == write_register_input)) begin
      read_data1 = wb_write_data;
    end
`endif
  end

  always_comb begin
    read_data2 = (read_reg2 == '0) ? '0 : regs_q[read_reg2];
`ifdef WB_REGFILE_BYPASS_EN
    if (wb_reg_write && (read_reg2 == write_register_input)) begin
      read_data2 = wb_write_data;
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile
// Honours WB_REGFILE_BYPASS_EN when defined for the build.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        startin;
  logic [31:0] read_data_input;
  logic [31:0] alu_result_input;
  logic [4:0]  write_register_input;
  logic [1:0]  WB_input;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] wb_write_data;
  logic        wb_reg_write;
  logic [31:0] commit_count;

  int checks = 0;
  int passed = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock),
    .startin(startin),
    .read_data_input(read_data_input),
    .alu_result_input(alu_result_input),
    .write_register_input(write_register_input),
    .WB_input(WB_input),
    .read_reg1(read_reg1),
    .read_reg2(read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .wb_write_data(wb_write_data),
    .wb_reg_write(wb_reg_write),
    .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] m_wdata();
    return WB_input[0] ? read_data_input : alu_result_input;
  endfunction

  function automatic logic m_we();
    return WB_input[1] && (write_register_input != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
    if (m_we() && idx == write_register_input) return m_wdata();
`endif
    return m_regs[idx];
  endfunction

  task automatic drive(input logic [1:0] wb, input logic [4:0] addr, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [4:0] r1, input logic [4:0] r2,
                       input logic rst);
    WB_input = wb; write_register_input = addr; alu_result_input = alu;
    read_data_input = ld; read_reg1 = r1; read_reg2 = r2; startin = rst;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    if (startin) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (m_we()) begin
      m_regs[write_register_input] = m_wdata();
      m_count = m_count + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      drive(2'b10 | 2'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom, $urandom, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (commit_count !== 32'd0) $display("FAIL reset_count: got %h expected %h", commit_count, 32'd0); else passed++;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i); #1;
      checks++; if (read_data1 !== 32'd0) $display("FAIL reset_r1[%0d]: got %h expected %h", i, read_data1, 32'd0); else passed++;
      checks++; if (read_data2 !== 32'd0) $display("FAIL reset_r2[%0d]: got %h expected %h", 31 - i, read_data2, 32'd0); else passed++;
    end
  endtask

  task automatic test_alu_commit();
    drive(2'b10, 5'd8, 32'h1234ABCD, 32'hDEADBEEF, 5'd8, 5'd0, 1'b0);
    checks++; if (wb_write_data !== 32'h1234ABCD) $display("FAIL alu_wdata: got %h expected %h", wb_write_data, 32'h1234ABCD); else passed++;
    checks++; if (wb_reg_write !== 1'b1) $display("FAIL alu_we: got %b expected %b", wb_reg_write, 1'b1); else passed++;
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0, 1'b0);
    checks++; if (read_data1 !== 32'h1234ABCD) $display("FAIL alu_r8: got %h expected %h", read_data1, 32'h1234ABCD); else passed++;
    checks++; if (commit_count !== 32'd1) $display("FAIL alu_count: got %h expected %h", commit_count, 32'd1); else passed++;
  endtask

  task automatic test_load_commit();
    logic [31:0] cnt0;
    cnt0 = m_count;
    drive(2'b11, 5'd9, 32'h0BADF00D, 32'hCAFEF00D, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_write_data !== 32'hCAFEF00D) $display("FAIL load_wdata: got %h expected %h", wb_write_data, 32'hCAFEF00D); else passed++;
    tick();
    drive(2'b01, 5'd10, $urandom, $urandom, 5'd9, 5'd10, 1'b0);
    checks++; if (read_data1 !== 32'hCAFEF00D) $display("FAIL load_r9: got %h expected %h", read_data1, 32'hCAFEF00D); else passed++;
    checks++; if (wb_reg_write !== 1'b0) $display("FAIL load_nowrite_we: got %b expected %b", wb_reg_write, 1'b0); else passed++;
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd10, 5'd9, 1'b0);
    checks++; if (read_data1 !== m_regs[10]) $display("FAIL load_r10: got %h expected %h", read_data1, m_regs[10]); else passed++;
    checks++; if (commit_count !== cnt0 + 32'd1) $display("FAIL load_count: got %h expected %h", commit_count, cnt0 + 32'd1); else passed++;
  endtask

  task automatic test_zero_guard();
    logic [31:0] cnt0;
    cnt0 = m_count;
    drive(2'b10, 5'd0, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0, 1'b0);
    checks++; if (wb_reg_write !== 1'b0) $display("FAIL zero_we: got %b expected %b", wb_reg_write, 1'b0); else passed++;
    checks++; if (read_data1 !== 32'd0) $display("FAIL zero_pre_r0: got %h expected %h", read_data1, 32'd0); else passed++;
    tick();
    checks++; if (read_data2 !== 32'd0) $display("FAIL zero_post_r0: got %h expected %h", read_data2, 32'd0); else passed++;
    checks++; if (commit_count !== cnt0) $display("FAIL zero_count: got %h expected %h", commit_count, cnt0); else passed++;
  endtask

  task automatic test_raw();
    logic [31:0] exp_pre;
`ifdef WB_REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    drive(2'b10, 5'd5, 32'h11, 32'd0, 5'd0, 5'd0, 1'b0);
    tick();
    drive(2'b10, 5'd5, 32'h22, 32'h99, 5'd5, 5'd5, 1'b0);
    checks++; if (read_data1 !== exp_pre) $display("FAIL raw_pre_r1: got %h expected %h", read_data1, exp_pre); else passed++;
    checks++; if (read_data2 !== exp_pre) $display("FAIL raw_pre_r2: got %h expected %h", read_data2, exp_pre); else passed++;
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5, 1'b0);
    checks++; if (read_data1 !== 32'h22) $display("FAIL raw_post_r1: got %h expected %h", read_data1, 32'h22); else passed++;
    checks++; if (read_data2 !== 32'h22) $display("FAIL raw_post_r2: got %h expected %h", read_data2, 32'h22); else passed++;
  endtask

  task automatic test_reset_collision();
    drive(2'b10, 5'd3, 32'h55, 32'd0, 5'd3, 5'd0, 1'b1);
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0, 1'b0);
    checks++; if (read_data1 !== 32'd0) $display("FAIL coll_r3: got %h expected %h", read_data1, 32'd0); else passed++;
    checks++; if (commit_count !== 32'd0) $display("FAIL coll_count: got %h expected %h", commit_count, 32'd0); else passed++;
    drive(2'b10, 5'd3, 32'h55, 32'd0, 5'd3, 5'd0, 1'b0);
    tick();
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd3, 5'd0, 1'b0);
    checks++; if (read_data1 !== 32'h55) $display("FAIL coll2_r3: got %h expected %h", read_data1, 32'h55); else passed++;
    checks++; if (commit_count !== 32'd1) $display("FAIL coll2_count: got %h expected %h", commit_count, 32'd1); else passed++;
  endtask

  task automatic test_random();
    logic [4:0] addr;
    for (int n = 0; n < 400; n++) begin
      addr = 5'($urandom_range(0, 31));
      drive(2'($urandom_range(0, 3)), addr, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? addr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? addr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 49) == 0));
      checks++; if (wb_write_data !== m_wdata()) $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, wb_write_data, m_wdata()); else passed++;
      checks++; if (wb_reg_write !== m_we()) $display("FAIL rnd_we[%0d]: got %b expected %b", n, wb_reg_write, m_we()); else passed++;
      checks++; if (read_data1 !== m_read(read_reg1)) $display("FAIL rnd_r1[%0d]: got %h expected %h", n, read_data1, m_read(read_reg1)); else passed++;
      checks++; if (read_data2 !== m_read(read_reg2)) $display("FAIL rnd_r2[%0d]: got %h expected %h", n, read_data2, m_read(read_reg2)); else passed++;
      tick();
      checks++; if (commit_count !== m_count) $display("FAIL rnd_count[%0d]: got %h expected %h", n, commit_count, m_count); else passed++;
    end
  endtask

  initial begin
    m_count = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    drive(2'b00, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    tick();
    tick();
    test_reset();
    test_alu_commit();
    test_load_commit();
    test_zero_guard();
    test_raw();
    test_reset_collision();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
